// File: rtl/life_grid_engine_pkg.sv
// Shared constants, neighbour-count type and flat cell indexing for the
// Life grid engine.
package life_pkg;

  localparam int unsigned BIRTH_CNT   = 3;
  localparam int unsigned SURVIVE_CNT = 2;

  typedef logic [3:0] ncount_t;

  function automatic int idx(int r, int c, int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/life_grid_engine_cell.sv
// Next-state rule for one cell: birth on exactly BIRTH_CNT live neighbours,
// survival on SURVIVE_CNT when already alive.
module life_cell_next
  import life_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic       self,
  output logic       nxt
);

  ncount_t cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + ncount_t'(nbr[i]);
    end
    nxt = (cnt == ncount_t'(BIRTH_CNT)) ||
          (self && (cnt == ncount_t'(SURVIVE_CNT)));
  end

endmodule

// File: rtl/life_grid_engine.sv
// Conway Life grid engine: one generation per advance, load/advance/hold
// priority, toroidal or dead-border edges chosen by WRAP.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] data,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 empty
);

  logic [ROWS*COLS-1:0] nxt_grid;
  logic                 step_d;
  logic                 step_armed;
  logic                 step_edge;
  logic                 advance;

  // Each cell sees a 3x3 window; the centre bit is the cell itself.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [8:0] win;
      for (genvar dr = 0; dr < 3; dr++) begin : g_dr
        for (genvar dc = 0; dc < 3; dc++) begin : g_dc
          localparam int RR = r + dr - 1;
          localparam int CC = c + dc - 1;
          localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
          localparam int RW = (RR + ROWS) % ROWS;
          localparam int CW = (CC + COLS) % COLS;
          if ((WRAP != 0) || INSIDE) begin : g_live
            assign win[dr*3+dc] = q[idx(RW, CW, COLS)];
          end else begin : g_dead
            assign win[dr*3+dc] = 1'b0;
          end
        end
      end

      life_cell_next u_cell (
        .nbr  ({win[8:5], win[3:0]}),
        .self (win[4]),
        .nxt  (nxt_grid[idx(r, c, COLS)])
      );
    end
  end

  // step_armed blocks a step that was already high across reset release
  // from being seen as a fresh rising edge; it arms once step is seen low.
  assign step_edge = step & ~step_d & step_armed;
  assign advance   = run | step_edge;
  assign empty     = ~|q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q          <= '0;
      gen_count  <= '0;
      stable     <= 1'b0;
      step_d     <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      step_d <= step;
      if (!step) begin
        step_armed <= 1'b1;
      end
      if (load) begin
        q         <= data;
        gen_count <= '0;
        stable    <= 1'b0;
      end else if (advance) begin
        q         <= nxt_grid;
        gen_count <= gen_count + GEN_W'(1);
        stable    <= (nxt_grid == q);
      end
    end
  end

endmodule
